// File: rtl/seq_multiplier_4bit.sv
// 4x4 unsigned shift-and-add multiplier, 8-bit product.
// One adder_4bit step per RUN cycle; done strobes for one cycle.
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  assign {cout, s} = a + b + {4'b0, cin};
endmodule

module seq_multiplier_4bit (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic B0,
  input  logic B1,
  input  logic B2,
  input  logic B3,
  output logic P0,
  output logic P1,
  output logic P2,
  output logic P3,
  output logic P4,
  output logic P5,
  output logic P6,
  output logic P7,
  output logic busy,
  output logic done
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, nstate;
  logic [3:0]  m, q, acc;
  logic [1:0]  cnt;
  logic [7:0]  preg;
  logic [3:0]  a_v, b_v;
  logic [3:0]  add_b, sum;
  logic        cout;
  logic        load;
  logic [7:0]  shifted;

  assign a_v = {A3, A2, A1, A0};
  assign b_v = {B3, B2, B1, B0};

  assign add_b = q[0] ? m : 4'b0;

  adder_4bit u_add (
    .a    (acc),
    .b    (add_b),
    .cin  (1'b0),
    .s    (sum),
    .cout (cout)
  );

  assign shifted = {cout, sum, q[3:1]};

  // DONE accepts a new start so a held start issues every 5 cycles
  assign load = start && (state == IDLE || state == DONE);

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (start) nstate = RUN;
      RUN:  if (cnt == 2'd3) nstate = DONE;
      DONE: nstate = start ? RUN : IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      m     <= '0;
      q     <= '0;
      acc   <= '0;
      cnt   <= '0;
      preg  <= '0;
    end else begin
      state <= nstate;
      if (load) begin
        m   <= a_v;
        q   <= b_v;
        acc <= '0;
        cnt <= '0;
      end else if (state == RUN) begin
        {acc, q} <= shifted;
        cnt      <= cnt + 2'd1;
        if (cnt == 2'd3) preg <= shifted;
      end
    end
  end

  assign {P7, P6, P5, P4, P3, P2, P1, P0} = preg;
  assign busy = (state != IDLE);
  assign done = (state == DONE);
endmodule

// File: tb/tb_seq_multiplier_4bit.sv
// Self-checking bench for seq_multiplier_4bit.
// Cycle-level product model plus directed literal checks.
module tb_seq_multiplier_4bit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] av = '0;
  logic [3:0] bv = '0;
  logic P0, P1, P2, P3, P4, P5, P6, P7;
  logic busy, done;
  logic [7:0] p;

  int checks = 0;
  int errors = 0;

  // model: cycles remaining until idle, pending product
  int         rem = 0;
  logic [7:0] pend = '0;
  logic [7:0] exp_p = '0;
  int         n_acc = 0;
  int         n_done = 0;

  always #5 clk = ~clk;

  assign p = {P7, P6, P5, P4, P3, P2, P1, P0};

  seq_multiplier_4bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A0    (av[0]),
    .A1    (av[1]),
    .A2    (av[2]),
    .A3    (av[3]),
    .B0    (bv[0]),
    .B1    (bv[1]),
    .B2    (bv[2]),
    .B3    (bv[3]),
    .P0    (P0),
    .P1    (P1),
    .P2    (P2),
    .P3    (P3),
    .P4    (P4),
    .P5    (P5),
    .P6    (P6),
    .P7    (P7),
    .busy  (busy),
    .done  (done)
  );

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // reference: product appears 5 cycles after an accepted start
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   = 0;
      exp_p = '0;
    end else begin
      if (start && rem <= 1) begin
        rem  = 5;
        pend = 8'(av * bv);
        n_acc++;
      end else if (rem > 0) begin
        rem--;
      end
      if (rem == 1) exp_p = pend;
    end
  end

  always @(negedge clk) begin
    chk("busy", int'(busy), int'(rem > 0));
    chk("done", int'(done), int'(rem == 1));
    chk("prod", int'(p), int'(exp_p));
    if (done) n_done++;
  end

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic op(input logic [3:0] a, input logic [3:0] b,
                    input logic [7:0] lit, input string nm);
    int n;
    @(negedge clk);
    av = a;
    bv = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, n, 5);
    chk({nm, "_lit"}, int'(p), int'(lit));
  endtask

  int cnt_d, lowb;

  initial begin
    #12;
    chk("rst_p", int'(p), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    op(4'd15, 4'd15, 8'hE1, "15x15");
    op(4'd3, 4'd5, 8'h0F, "3x5");
    @(negedge clk);
    av = 4'd0;
    bv = 4'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_0F", int'(p), 8'h0F);
      @(negedge clk);
    end
    wait_done("0x9");
    chk("0x9_lit", int'(p), 0);

    // held start: back-to-back issue
    @(negedge clk);
    av = 4'd7;
    bv = 4'd6;
    start = 1'b1;
    cnt_d = 0;
    lowb = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        cnt_d++;
        chk("held_lit", int'(p), 8'h2A);
      end
      if (i < 10 && !busy) lowb++;
    end
    start = 1'b0;
    chk("held_dones", cnt_d, 2);
    chk("held_busy_gap", lowb, 0);
    repeat (6) @(negedge clk);

    // restarts during RUN ignored
    av = 4'd13;
    bv = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    av = 4'd2;
    bv = 4'd2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    av = 4'd4;
    bv = 4'd5;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_done", int'(done), 1);
    chk("ign_lit", int'(p), 91);
    repeat (3) @(negedge clk);

    // async reset mid-RUN
    av = 4'd9;
    bv = 4'd11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_p", int'(p), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_d = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) cnt_d++;
    end
    chk("ar_nodone", cnt_d, 0);
    op(4'd9, 4'd11, 8'h63, "9x11");
    repeat (2) @(negedge clk);

    // exhaustive back-to-back
    n_acc = 0;
    n_done = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        av = 4'(a);
        bv = 4'(b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("exh");
        chk("exh_prod", int'(p), a * b);
        @(negedge clk);
      end
    end
    chk("exh_dones", n_done, 256);
    chk("exh_accepts", n_acc, 256);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
